// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared constants for the 4:1 mux scan sequencer: state
//               encoding, channel count, select width and a channel helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Scan sequencer states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // True when the select points at the highest-numbered channel
    function automatic logic is_last_ch(input logic [SEL_W-1:0] sel);
        return (sel == SEL_W'(NUM_CH - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Loadable down-counter timing the settle interval on each
//               mux channel. Stops at zero; zero flag is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] r_cnt;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps the 4:1 mux select through channels 0..3, waits DWELL
//               settle cycles on each, samples the mux output once per
//               channel and presents a 4-bit snapshot with start/busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mux_out,
    output logic              sel1,
    output logic              sel0,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] result,
    output logic              result_valid
);

    // Counter reload value: DWELL-1 gives exactly DWELL cycles in SETTLE
    localparam logic [CW-1:0] c_dwell_m1 = CW'(DWELL - 1);

    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic              r_busy;
    logic              r_done;
    logic [NUM_CH-1:0] r_result;
    logic              r_result_valid;

    logic w_load;
    logic w_dec;
    logic w_zero;

    // Reload on scan start and whenever another channel follows a sample
    assign w_load = ((r_state == IDLE) && start) ||
                    ((r_state == SAMPLE) && !is_last_ch(r_sel));
    assign w_dec  = (r_state == SETTLE) && !w_zero;

    dwell_counter #(
        .CW (CW)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (c_dwell_m1),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // Scan sequencer with registered select, status and snapshot outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_sel          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state        <= SETTLE;
                        r_sel          <= '0;
                        r_busy         <= 1'b1;
                        r_result       <= '0;
                        r_result_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (w_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_result[r_sel] <= mux_out;
                    if (is_last_ch(r_sel)) begin
                        r_state <= DONE;
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= SETTLE;
                        r_sel   <= r_sel + SEL_W'(1);
                    end
                end
                DONE: begin
                    r_result_valid <= 1'b1;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sel1         = r_sel[1];
    assign sel0         = r_sel[0];
    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. Two instances
//               (DWELL=4 and DWELL=1) are driven with directed and random
//               stimulus; a timeline reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int D0   = 4;
    localparam int D1   = 1;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, one entry per instance
    logic       rst_v   [2];
    logic       start_v [2];
    logic [3:0] in_v    [2];

    logic sel1_a, sel0_a, busy_a, done_a, rv_a, mux_a;
    logic sel1_b, sel0_b, busy_b, done_b, rv_b, mux_b;
    logic [3:0] res_a, res_b;

    // Behavioural 4:1 mux in front of each instance
    assign mux_a = in_v[0][{sel1_a, sel0_a}];
    assign mux_b = in_v[1][{sel1_b, sel0_b}];

    mux_scan_ctrl #(.DWELL(D0), .CW(8)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .mux_out(mux_a),
        .sel1(sel1_a), .sel0(sel0_a), .busy(busy_a), .done(done_a),
        .result(res_a), .result_valid(rv_a)
    );

    mux_scan_ctrl #(.DWELL(D1), .CW(8)) u_dut_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .mux_out(mux_b),
        .sel1(sel1_b), .sel0(sel0_b), .busy(busy_b), .done(done_b),
        .result(res_b), .result_valid(rv_b)
    );

    logic [1:0] sel_o  [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       rv_o   [2];
    logic [3:0] res_o  [2];
    assign sel_o[0]  = {sel1_a, sel0_a};
    assign sel_o[1]  = {sel1_b, sel0_b};
    assign busy_o[0] = busy_a;
    assign busy_o[1] = busy_b;
    assign done_o[0] = done_a;
    assign done_o[1] = done_b;
    assign rv_o[0]   = rv_a;
    assign rv_o[1]   = rv_b;
    assign res_o[0]  = res_a;
    assign res_o[1]  = res_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int u, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", name, u, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a scan accepted at edge A occupies 4*(D+1) cycles,
    // channel c is sampled at edge A+(c+1)*(D+1) (select = c during the
    // preceding D+1 cycles), done is seen after edge A+4*(D+1), and the
    // block is idle again for a start at edge A+4*(D+1)+2.
    // ------------------------------------------------------------------
    int         cyc = 0;
    logic [3:0] in_hist [2][0:HMAX-1];
    int         last_acc  [2];
    bit         active    [2];
    bit         exp_valid [2];
    logic [3:0] exp_res   [2];
    int         q0[$];
    int         q1[$];

    function automatic int dw(input int u);
        return (u == 0) ? D0 : D1;
    endfunction

    function automatic int tot(input int u);
        return 4 * (dw(u) + 1);
    endfunction

    function automatic logic [3:0] snap(input int u, input int a);
        logic [3:0] s;
        logic [3:0] h;
        for (int c = 0; c < 4; c++) begin
            h    = in_hist[u][a + (c + 1) * (dw(u) + 1)];
            s[c] = h[c];
        end
        return s;
    endfunction

    initial begin
        for (int u = 0; u < 2; u++) begin
            active[u]    = 1'b0;
            exp_valid[u] = 1'b0;
            exp_res[u]   = 4'h0;
            last_acc[u]  = -1000;
        end
    end

    // Advance the model on each edge with the inputs the DUT sees there
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            in_hist[u][cyc] = in_v[u];
            if (rst_v[u]) begin
                active[u]    = 1'b0;
                exp_valid[u] = 1'b0;
                exp_res[u]   = 4'h0;
                if (u == 0) q0.delete(); else q1.delete();
            end else if (active[u] && (cyc == last_acc[u] + tot(u) + 1)) begin
                active[u]    = 1'b0;
                exp_valid[u] = 1'b1;
                exp_res[u]   = snap(u, last_acc[u]);
            end else if (!active[u] && start_v[u]) begin
                active[u]    = 1'b1;
                last_acc[u]  = cyc;
                exp_valid[u] = 1'b0;
                exp_res[u]   = 4'h0;
                if (u == 0) q0.push_back(cyc); else q1.push_back(cyc);
            end
        end
        cyc++;
    end

    // Monitor: per-cycle output checks plus scoreboard pop on every done
    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int u = 0; u < 2; u++) begin
                int e;
                int k;
                int a;
                int eb;
                int ed;
                int es;
                e  = cyc - 1;
                eb = 0;
                ed = 0;
                es = 0;
                if (active[u]) begin
                    k = e - last_acc[u];
                    if (k < tot(u)) begin
                        eb = 1;
                        es = k / (dw(u) + 1);
                    end else if (k == tot(u)) begin
                        ed = 1;
                    end
                end
                chk("busy", u, int'(busy_o[u]), eb);
                chk("done", u, int'(done_o[u]), ed);
                chk("sel", u, int'(sel_o[u]), es);
                chk("result_valid", u, int'(rv_o[u]), int'(exp_valid[u]));
                if (!active[u]) chk("result_hold", u, int'(res_o[u]), int'(exp_res[u]));
                if (done_o[u]) begin
                    if (((u == 0) ? q0.size() : q1.size()) == 0) begin
                        chk("unexpected_done", u, 1, 0);
                    end else begin
                        a = (u == 0) ? q0.pop_front() : q1.pop_front();
                        chk("done_latency", u, e - a, tot(u));
                        chk("snapshot", u, int'(res_o[u]), int'(snap(u, a)));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start on instance u and leave the bench in scan cycle k=0
    task automatic launch(input int u);
        start_v[u] = 1'b1;
        tick();
        start_v[u] = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_v[u]   = 1'b1;
            start_v[u] = 1'($urandom);
            in_v[u]    = 4'($urandom);
        end
        // Reset held two cycles with random start and mux inputs
        for (int i = 0; i < 2; i++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                start_v[u] = 1'($urandom);
                in_v[u]    = 4'($urandom);
            end
        end
        chk("reset_sel", 0, int'({sel1_a, sel0_a}), 0);
        chk("reset_result", 0, int'(res_a), 0);
        chk("reset_valid", 1, int'(rv_b), 0);
        for (int u = 0; u < 2; u++) begin
            rst_v[u]   = 1'b0;
            start_v[u] = 1'b0;
        end
        tick();

        // Basic scan: in0=1 in1=0 in2=1 in3=1
        in_v[0] = 4'b1101;
        launch(0);
        repeat (25) tick();
        chk("basic_result", 0, int'(res_a), 4'b1101);
        chk("basic_valid", 0, int'(rv_a), 1);

        // Extra start pulses during the scan are ignored
        launch(0);
        for (int k = 0; k < 25; k++) begin
            start_v[0] = (k == 3 || k == 12);
            tick();
        end
        start_v[0] = 1'b0;
        chk("busy_start_result", 0, int'(res_a), 4'b1101);

        // Channel 2 input rises one cycle before its sample
        in_v[0] = 4'b1001;
        launch(0);
        for (int k = 0; k < 25; k++) begin
            if (k == 13) in_v[0][2] = 1'b1;
            tick();
        end
        chk("late_rise_bit2", 0, int'(res_a[2]), 1);

        // Same, then falls again right after the sample
        in_v[0] = 4'b1001;
        launch(0);
        for (int k = 0; k < 25; k++) begin
            if (k == 13) in_v[0][2] = 1'b1;
            if (k == 15) in_v[0][2] = 1'b0;
            tick();
        end
        chk("post_sample_bit2", 0, int'(res_a[2]), 1);

        // Reset during channel-2 settle aborts the scan
        in_v[0] = 4'($urandom);
        launch(0);
        repeat (12) tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        chk("abort_sel", 0, int'({sel1_a, sel0_a}), 0);
        chk("abort_busy", 0, int'(busy_a), 0);
        chk("abort_result", 0, int'(res_a), 0);
        chk("abort_valid", 0, int'(rv_a), 0);
        repeat (30) tick();

        // DWELL=1 instance: single scan, then start held high
        in_v[1] = 4'($urandom);
        launch(1);
        repeat (12) tick();
        start_v[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_v[1] = 4'($urandom);
            tick();
        end
        start_v[1] = 1'b0;
        repeat (12) tick();

        // Random traffic on both instances with occasional resets
        for (int i = 0; i < 1500; i++) begin
            for (int u = 0; u < 2; u++) begin
                start_v[u] = ($urandom_range(0, 9) == 0);
                in_v[u]    = 4'($urandom);
                rst_v[u]   = ($urandom_range(0, 299) == 0);
            end
            tick();
        end
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0;
            rst_v[u]   = 1'b0;
        end
        repeat (40) tick();

        chk("pending_scans", 0, q0.size(), 0);
        chk("pending_scans", 1, q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
